// File: rtl/mul_norm_round_pipe_if.sv
// Handshake bundle between the significand multiplier array and the
// normalise/round pipeline, and from the pipeline to the MAC accumulator.
interface mul_norm_round_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int PW = 2*MAN_W + 2;
    localparam int RW = 1 + EXP_W + MAN_W;

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic signed [EXP_W+1:0] in_exp;
    logic [PW-1:0]           in_prod;

    logic                    out_valid;
    logic                    out_ready;
    logic [RW-1:0]           out_result;
    logic                    out_ovf;
    logic                    out_unf;
    logic                    out_inx;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inx
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf, out_inx
    );
endinterface

// File: rtl/mul_norm_round_pipe.sv
// Two-stage normalise (S1) and round/exception (S2) pipeline turning a raw
// significand product and biased exponent sum into a packed result.
module mul_norm_round_pipe #(
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 10,
    parameter int RND_MODE = 1
) (
    input logic                  clk,
    input logic                  rst,
    mul_norm_round_pipe_if.slave bus
);
    localparam int PW = 2*MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int RW = 1 + EXP_W + MAN_W;
    localparam logic [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

    typedef struct packed {
        logic             sign;
        logic [EW-1:0]    exp;
        logic [MAN_W-1:0] man;
        logic             guard;
        logic             sticky;
        logic             zero;
    } norm_t;

    typedef struct packed {
        logic [RW-1:0] result;
        logic          ovf;
        logic          unf;
        logic          inx;
    } res_t;

    logic  s1_valid, s2_valid;
    norm_t s1_d, s1_q;
    res_t  s2_d, s2_q;
    logic  adv1, adv2;

    // A stage may load when it is empty or its content is leaving this cycle.
    assign adv2         = !s2_valid || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1;

    // S1: align on the product's leading bit, split into mantissa/guard/sticky.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.in_sign;
        s1_d.zero = (bus.in_prod == '0);
        if (bus.in_prod[PW-1]) begin
            s1_d.exp    = bus.in_exp + EW'(1);
            s1_d.man    = bus.in_prod[PW-2 -: MAN_W];
            s1_d.guard  = bus.in_prod[PW-2-MAN_W];
            s1_d.sticky = |bus.in_prod[PW-3-MAN_W:0];
        end else begin
            s1_d.exp    = bus.in_exp;
            s1_d.man    = bus.in_prod[PW-3 -: MAN_W];
            s1_d.guard  = bus.in_prod[PW-3-MAN_W];
            s1_d.sticky = |bus.in_prod[PW-4-MAN_W:0];
        end
    end

    // S2: round, then classify on the post-carry exponent.
    logic             inc;
    logic [MAN_W:0]   man_sum;
    logic [EW-1:0]    exp_f;

    always_comb begin
        inc     = (RND_MODE == 1) && s1_q.guard && (s1_q.sticky || s1_q.man[0]);
        man_sum = {1'b0, s1_q.man} + (MAN_W+1)'(inc);
        // A carry out leaves the low mantissa bits already zero.
        exp_f   = s1_q.exp + EW'(man_sum[MAN_W]);

        s2_d        = '0;
        s2_d.result = {s1_q.sign, exp_f[EXP_W-1:0], man_sum[MAN_W-1:0]};
        s2_d.inx    = s1_q.guard || s1_q.sticky;
        if (s1_q.zero) begin
            s2_d.result = {s1_q.sign, {(RW-1){1'b0}}};
            s2_d.inx    = 1'b0;
        end else if ($signed(exp_f) >= $signed(EXP_MAX)) begin
            s2_d.result = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s2_d.ovf    = 1'b1;
            s2_d.inx    = 1'b1;
        end else if ($signed(exp_f) <= 0) begin
            s2_d.result = {s1_q.sign, {(RW-1){1'b0}}};
            s2_d.unf    = 1'b1;
            s2_d.inx    = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // values from before the edge; data registers are reset too so the output
    // bus reads zero after reset rather than stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) s1_q <= s1_d;
            end
            // Output register only changes when it advances, so a stalled
            // beat holds result and flags stable.
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) s2_q <= s2_d;
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_q.result;
    assign bus.out_ovf    = s2_q.ovf;
    assign bus.out_unf    = s2_q.unf;
    assign bus.out_inx    = s2_q.inx;
endmodule
